// File: rtl/dds_wave_gen_if.sv
// Configuration handshake and sample output bundle for dds_wave_gen.
// master = config source / sample consumer, slave = the DDS core.
interface dds_wave_gen_if #(
    parameter int unsigned PHASE_W = 32,
    parameter int unsigned OUT_W   = 24
);
    logic               cfg_valid;
    logic               cfg_ready;
    logic [PHASE_W-1:0] cfg_ftw;
    logic [1:0]         cfg_wave_sel;
    logic [PHASE_W-1:0] phase_acc;
    logic [OUT_W-1:0]   wave_out;
    logic               wave_valid;

    modport master (
        output cfg_valid, cfg_ftw, cfg_wave_sel,
        input  cfg_ready, phase_acc, wave_out, wave_valid
    );

    modport slave (
        input  cfg_valid, cfg_ftw, cfg_wave_sel,
        output cfg_ready, phase_acc, wave_out, wave_valid
    );
endinterface

// File: rtl/dds_wave_gen.sv
// Phase-accumulator DDS with sine/square/triangle/sawtooth output and wrap-aligned reconfig.
// Optional DDS_PHASE_DITHER_EN adds LFSR dither to the sine LUT addressing.
module dds_wave_gen #(
    parameter int unsigned PHASE_W = 32,
    parameter int unsigned OUT_W   = 24,
    parameter int unsigned LUT_AW  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    dds_wave_gen_if.slave bus
);
    localparam int unsigned LUT_N  = 1 << LUT_AW;
    localparam int unsigned LUT_DW = OUT_W - 1;
    localparam real         HALF_PI = 1.5707963267948966;
    localparam logic [OUT_W-1:0] MID = {1'b1, {(OUT_W-1){1'b0}}};

    typedef enum logic [0:0] {StIdle, StPending} cfg_state_e;

    // Quarter-wave sine table, sampled at bin centres so no entry is zero or full-scale.
    logic [LUT_DW-1:0] lut [LUT_N];
    for (genvar a = 0; a < LUT_N; a++) begin : g_lut
        assign lut[a] = LUT_DW'($rtoi(real'((1 << LUT_DW) - 1)
                        * $sin(HALF_PI * (real'(a) + 0.5) / real'(LUT_N)) + 0.5));
    end

    cfg_state_e         state_q;
    logic               ready_q;
    logic [PHASE_W-1:0] shadow_ftw_q;
    logic [1:0]         shadow_sel_q;
    logic [PHASE_W-1:0] ftw_q;
    logic [1:0]         sel_q;
    logic [PHASE_W-1:0] phase_q;

    logic [PHASE_W:0]   sum;
    logic               wrap;
    logic               commit;

    assign sum    = {1'b0, phase_q} + {1'b0, ftw_q};
    assign wrap   = enable & sum[PHASE_W];
    assign commit = wrap | ~enable | (ftw_q == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            ready_q      <= 1'b1;
            shadow_ftw_q <= '0;
            shadow_sel_q <= '0;
            ftw_q        <= '0;
            sel_q        <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.cfg_valid) begin
                        shadow_ftw_q <= bus.cfg_ftw;
                        shadow_sel_q <= bus.cfg_wave_sel;
                        state_q      <= StPending;
                        ready_q      <= 1'b0;
                    end
                end
                StPending: begin
                    // Committing on the wrap edge lines the new sel up with the first post-wrap phase.
                    if (commit) begin
                        ftw_q   <= shadow_ftw_q;
                        sel_q   <= shadow_sel_q;
                        state_q <= StIdle;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= '0;
        end else if (enable) begin
            phase_q <= sum[PHASE_W-1:0];
        end
    end

    logic [PHASE_W-1:0] sine_phase;
`ifdef DDS_PHASE_DITHER_EN
    logic [19:0] lfsr_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= 20'hACE1;
        end else begin
            lfsr_q <= {lfsr_q[18:0], lfsr_q[19] ^ lfsr_q[16]};
        end
    end
    assign sine_phase = phase_q + PHASE_W'(lfsr_q);
`else
    assign sine_phase = phase_q;
`endif

    // S1: decode. Square/triangle/sawtooth always use the undithered phase.
    logic [1:0]        s1_quad_q;
    logic [LUT_AW-1:0] s1_addr_q;
    logic [1:0]        s1_sel_q;
    logic [OUT_W-1:0]  s1_hi_q;
    logic              en_d1_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_quad_q <= '0;
            s1_addr_q <= '0;
            s1_sel_q  <= '0;
            s1_hi_q   <= '0;
            en_d1_q   <= 1'b0;
        end else begin
            s1_quad_q <= sine_phase[PHASE_W-1 -: 2];
            s1_addr_q <= sine_phase[PHASE_W-3 -: LUT_AW];
            s1_sel_q  <= sel_q;
            s1_hi_q   <= phase_q[PHASE_W-1 -: OUT_W];
            en_d1_q   <= enable;
        end
    end

    // S2: LUT read and output mux.
    logic [LUT_AW-1:0] lut_idx;
    logic [LUT_DW-1:0] lut_val;
    logic [OUT_W-1:0]  tri_t;
    logic [OUT_W-1:0]  wave_d;
    logic [OUT_W-1:0]  wave_q;
    logic              valid_q;

    always_comb begin
        lut_idx = s1_quad_q[0] ? ~s1_addr_q : s1_addr_q;
        lut_val = lut[lut_idx];
        tri_t   = {s1_hi_q[OUT_W-2:0], 1'b0};
        wave_d  = s1_hi_q;
        case (s1_sel_q)
            2'd0:    wave_d = s1_quad_q[1] ? MID - {1'b0, lut_val} : MID + {1'b0, lut_val};
            2'd1:    wave_d = s1_hi_q[OUT_W-1] ? '0 : '1;
            2'd2:    wave_d = s1_hi_q[OUT_W-1] ? ~tri_t : tri_t;
            default: wave_d = s1_hi_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wave_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            wave_q  <= wave_d;
            valid_q <= en_d1_q;
        end
    end

    assign bus.cfg_ready  = ready_q;
    assign bus.phase_acc  = phase_q;
    assign bus.wave_out   = wave_q;
    assign bus.wave_valid = valid_q;
endmodule
